lms_ctr_boot_copier: RTL and testbench

// - Avalon-MM write master that sits directly upstream of the 8192x32 on-chip program memory.
// - Reads the firmware image from the SPI configuration flash (READ 0x03) and writes it into the RAM through its s1 port.
// - Holds the Nios CPU in reset (cpu_reset_req) until the copy completes.

---
 rtl/lms_ctr_boot_pkg.sv | 26 ++
 rtl/lms_ctr_boot_spi_shifter.sv | 63 ++++++
 rtl/lms_ctr_boot_copier.sv | 173 +++++++++++++++++
 tb/tb_lms_ctr_boot_copier.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lms_ctr_boot_pkg.sv
// Shared types and constants for the flash-to-RAM boot copier.
// BOOT_CHECKSUM_EN adds the CHECK state that verifies the trailer word.
package lms_ctr_boot_pkg;

    localparam int         FLASH_ADDR_W = 24;
    localparam int         WORD_W       = 32;
    localparam int         XFER_BITS    = 32;
    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WRITE,
`ifdef BOOT_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_FINISH
    } boot_state_t;

    // Flash streams byte 0 first; byte k belongs in bits [8k+7:8k].
    function automatic logic [WORD_W-1:0] flash_to_word(input logic [WORD_W-1:0] rx);
        return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endfunction

endpackage

// File: rtl/lms_ctr_boot_spi_shifter.sv
// SPI mode-0 shifter: SCLK divider plus 32-bit MSB-first TX/RX shift registers.
// go loads a transfer; last_bit is high during the high phase of the final bit, which ends after one clk.
module lms_ctr_boot_spi_shifter #(
    parameter int SCLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [5:0]  len_bits,
    input  logic [31:0] tx_data,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic [31:0] rx_data,
    output logic        last_bit
);

    localparam int DIV_W = $clog2(SCLK_DIV) + 1;

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bits_left;
    logic [31:0]      tx_sh;
    logic             tick;

    assign tick     = active && (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign last_bit = active && sclk && (bits_left == 6'd0);
    assign mosi     = tx_sh[31];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active    <= 1'b0;
            div_cnt   <= '0;
            bits_left <= '0;
            tx_sh     <= '0;
            rx_data   <= '0;
            sclk      <= 1'b0;
        end else if (go) begin
            active    <= 1'b1;
            div_cnt   <= '0;
            bits_left <= len_bits;
            tx_sh     <= tx_data;
            sclk      <= 1'b0;
        end else if (active) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (!sclk) begin
                if (tick) begin
                    sclk      <= 1'b1;
                    rx_data   <= {rx_data[30:0], miso};
                    bits_left <= bits_left - 1'b1;
                end
            end else if (bits_left == 6'd0) begin
                // Final bit: drop SCLK right away so the RAM write cycle sees it low.
                sclk   <= 1'b0;
                active <= 1'b0;
            end else if (tick) begin
                sclk  <= 1'b0;
                tx_sh <= {tx_sh[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/lms_ctr_boot_copier.sv
// Copies WORDS flash words (SPI READ burst) into program RAM, holding the CPU in reset until done.
// One single-cycle RAM write per word, no backpressure; BOOT_CHECKSUM_EN verifies a trailer word.
module lms_ctr_boot_copier
    import lms_ctr_boot_pkg::*;
#(
    parameter int                      WORDS      = 8192,
    parameter int                      ADDR_W     = 13,
    parameter logic [FLASH_ADDR_W-1:0] FLASH_BASE = 24'h0B0000,
    parameter int                      SCLK_DIV   = 2,
    parameter int                      AUTO_START = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_reset_req,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_writedata
);

    localparam int CNT_W = ADDR_W + 1;

    boot_state_t       state;
    logic              auto_pend;
    logic [CNT_W-1:0]  word_cnt;
    logic              launch;
    logic              last_word;
    logic              sh_go;
    logic [WORD_W-1:0] sh_tx;
    logic [WORD_W-1:0] sh_rx;
    logic              sh_last;

    assign launch         = (state == ST_IDLE) && (start || auto_pend);
    assign last_word      = (word_cnt == CNT_W'(WORDS - 1));
    assign mem_address    = word_cnt[ADDR_W-1:0];
    assign mem_chipselect = mem_write;
    assign mem_byteenable = {4{mem_write}};

    always_comb begin
        sh_go = 1'b0;
        sh_tx = '0;
        if (launch) begin
            sh_go = 1'b1;
            sh_tx = {SPI_CMD_READ, FLASH_BASE};
        end else if (state == ST_CMD) begin
            sh_go = sh_last;
        end else if (state == ST_WRITE) begin
`ifdef BOOT_CHECKSUM_EN
            sh_go = 1'b1;
`else
            sh_go = !last_word;
`endif
        end
    end

    lms_ctr_boot_spi_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (sh_go),
        .len_bits (6'(XFER_BITS)),
        .tx_data  (sh_tx),
        .miso     (spi_miso),
        .sclk     (spi_sclk),
        .mosi     (spi_mosi),
        .rx_data  (sh_rx),
        .last_bit (sh_last)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [WORD_W-1:0] sum;
    logic              error_q;
    logic              mismatch;

    assign mismatch = flash_to_word(sh_rx) != (~sum + WORD_W'(1));
    assign error    = error_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum     <= '0;
            error_q <= 1'b0;
        end else if (launch) begin
            sum     <= '0;
            error_q <= 1'b0;
        end else if (state == ST_DATA && sh_last) begin
            sum <= sum + flash_to_word(sh_rx);
        end else if (state == ST_CHECK && sh_last) begin
            error_q <= mismatch;
        end
    end
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            auto_pend     <= (AUTO_START != 0);
            busy          <= 1'b0;
            done          <= 1'b0;
            cpu_reset_req <= 1'b1;
            spi_cs_n      <= 1'b1;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            word_cnt      <= '0;
        end else begin
            mem_write <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state         <= ST_CMD;
                        auto_pend     <= 1'b0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        cpu_reset_req <= 1'b1;
                        spi_cs_n      <= 1'b0;
                        word_cnt      <= '0;
                    end
                end
                ST_CMD: begin
                    if (sh_last) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (sh_last) begin
                        state         <= ST_WRITE;
                        mem_write     <= 1'b1;
                        mem_writedata <= flash_to_word(sh_rx);
                    end
                end
                ST_WRITE: begin
                    word_cnt <= word_cnt + 1'b1;
                    if (!last_word) begin
                        state <= ST_DATA;
                    end else begin
`ifdef BOOT_CHECKSUM_EN
                        state <= ST_CHECK;
`else
                        state         <= ST_FINISH;
                        spi_cs_n      <= 1'b1;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        cpu_reset_req <= 1'b0;
`endif
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                ST_CHECK: begin
                    if (sh_last) begin
                        state         <= ST_FINISH;
                        spi_cs_n      <= 1'b1;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        cpu_reset_req <= mismatch;
                    end
                end
`endif
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lms_ctr_boot_copier.sv
// Bench for lms_ctr_boot_copier: SPI flash model, write scoreboard, directed copy scenarios.
`timescale 1ns/1ps
module tb_lms_ctr_boot_copier;

    localparam int          WORDS    = 16;
    localparam int          ADDR_W   = 4;
    localparam int          SCLK_DIV = 2;
    localparam logic [31:0] EXP_CMD  = 32'h030B0000;
`ifdef BOOT_CHECKSUM_EN
    localparam logic CSUM = 1'b1;
`else
    localparam logic CSUM = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n;
    logic start = 1'b0;
    logic spi_miso = 1'b0;
    logic busy, done, error, cpu_reset_req, spi_sclk, spi_cs_n, spi_mosi;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata;

    logic m_start = 1'b0;
    logic m_miso = 1'b0;
    logic m_busy, m_done, m_error, m_cpu, m_sclk, m_cs_n, m_mosi;
    logic [ADDR_W-1:0] m_addr;
    logic [3:0]  m_be;
    logic        m_cs, m_wr;
    logic [31:0] m_wdata;

    always #5 clk = ~clk;

    lms_ctr_boot_copier #(
        .WORDS(WORDS), .ADDR_W(ADDR_W), .FLASH_BASE(24'h0B0000), .SCLK_DIV(SCLK_DIV), .AUTO_START(1)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .error(error),
        .cpu_reset_req(cpu_reset_req), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata)
    );

    lms_ctr_boot_copier #(
        .WORDS(WORDS), .ADDR_W(ADDR_W), .FLASH_BASE(24'h0B0000), .SCLK_DIV(SCLK_DIV), .AUTO_START(0)
    ) u_manual (
        .clk(clk), .reset_n(reset_n), .start(m_start), .busy(m_busy), .done(m_done), .error(m_error),
        .cpu_reset_req(m_cpu), .spi_sclk(m_sclk), .spi_cs_n(m_cs_n), .spi_mosi(m_mosi),
        .spi_miso(m_miso), .mem_address(m_addr), .mem_byteenable(m_be),
        .mem_chipselect(m_cs), .mem_write(m_wr), .mem_writedata(m_wdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- flash model ----------------
    logic ovr_word0 = 1'b0;
    logic corrupt   = 1'b0;

    function automatic logic [31:0] image_word(input int i);
        if (i == 0 && ovr_word0) return 32'h44332211;
        return 32'hA5000000 + 32'(i);
    endfunction

    function automatic logic [31:0] trailer();
        logic [31:0] s;
        s = 32'd0;
        for (int j = 0; j < WORDS; j++) s += image_word(j);
        return (~s + 32'd1) ^ {31'd0, corrupt};
    endfunction

    logic [31:0] exp_cmd_q[$];
    wr_t         exp_q[$];
    logic [31:0] cmd_sh;
    int          rise_cnt = 0;
    int          cyc = 0;
    int          last_rise_cyc = 0;
    int          fl_j, fl_w, fl_r;
    logic [31:0] fl_word;

    always @(posedge clk) cyc++;
    always @(negedge spi_cs_n) rise_cnt = 0;

    always @(posedge spi_sclk) begin
        if (!spi_cs_n) begin
            if (rise_cnt % 32 != 0)
                check("sclk_period", cyc - last_rise_cyc, 2 * SCLK_DIV);
            last_rise_cyc = cyc;
            if (rise_cnt < 32) cmd_sh = {cmd_sh[30:0], spi_mosi};
            rise_cnt++;
            if (rise_cnt == 32) begin
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spi_cmd_unexpected: got %h, expected no command", cmd_sh);
                end else begin
                    check("spi_cmd", cmd_sh, exp_cmd_q.pop_front());
                end
            end
        end
    end

    always @(negedge spi_sclk) begin
        if (!spi_cs_n && rise_cnt >= 32) begin
            fl_j = rise_cnt - 32;
            fl_w = fl_j / 32;
            fl_r = fl_j % 32;
            fl_word = (fl_w < WORDS) ? image_word(fl_w) : trailer();
            spi_miso = fl_word[8 * (fl_r / 8) + 7 - (fl_r % 8)];
        end
    end

    // ---------------- write monitor ----------------
    int   wr_seen = 0;
    int   m_writes = 0;
    logic was_write = 1'b0;
    wr_t  exp_e;

    always @(negedge clk) begin
        if (m_wr) m_writes++;
        if (reset_n) begin
            if (was_write) check("sclk_after_write", 32'(spi_sclk), 0);
            was_write = mem_write;
            if (mem_write) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected: got addr %h data %h, expected no write", mem_address, mem_writedata);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_addr", 32'(mem_address), 32'(exp_e.addr));
                    check("wr_data", mem_writedata, exp_e.data);
                end
                check("sclk_in_write", 32'(spi_sclk), 0);
                check("wr_byteenable", 32'(mem_byteenable), 32'hF);
                check("wr_chipselect", 32'(mem_chipselect), 1);
                check("wr_cs_n_low", 32'(spi_cs_n), 0);
            end
        end else begin
            was_write = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic expect_copy();
        exp_cmd_q.push_back(EXP_CMD);
        for (int i = 0; i < WORDS; i++) exp_q.push_back('{ADDR_W'(i), image_word(i)});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_cpu_reset_req"}, 32'(cpu_reset_req), 1);
        check({tag, "_sclk"}, 32'(spi_sclk), 0);
        check({tag, "_cs_n"}, 32'(spi_cs_n), 1);
        check({tag, "_mosi"}, 32'(spi_mosi), 0);
        check({tag, "_mem_write"}, 32'(mem_write), 0);
        check({tag, "_mem_chipselect"}, 32'(mem_chipselect), 0);
        check({tag, "_mem_byteenable"}, 32'(mem_byteenable), 0);
        check({tag, "_mem_address"}, 32'(mem_address), 0);
        check({tag, "_mem_writedata"}, mem_writedata, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done_reached"}, 32'(done), 1);
    endtask

    task automatic wait_writes(input string tag, input int target);
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (wr_seen >= target) break;
        end
        check({tag, "_writes_reached"}, wr_seen, target);
    endtask

    task automatic post_checks(input string tag, input logic exp_err);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_cs_n"}, 32'(spi_cs_n), 1);
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_cpu_reset_req"}, 32'(cpu_reset_req), 32'(exp_err));
        check({tag, "_write_count"}, wr_seen, WORDS);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        check({tag, "_pending_cmds"}, exp_cmd_q.size(), 0);
    endtask

    initial begin
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #20 check_reset("por");

        // Auto-start copy after reset release
        wr_seen = 0;
        expect_copy();
        @(negedge clk) reset_n = 1'b1;
        wait_done("copy1");
        post_checks("copy1", 1'b0);
        check("copy1_data_held", mem_writedata, 32'hA500000F);

        // Byte ordering check on word 0, plus start pulse while busy at word 7
        repeat (3) @(negedge clk);
        ovr_word0 = 1'b1;
        wr_seen = 0;
        expect_copy();
        pulse_start();
        wait_writes("copy2_w7", 7);
        check("copy2_busy_at_w7", 32'(busy), 1);
        pulse_start();
        wait_done("copy2");
        post_checks("copy2", 1'b0);
        ovr_word0 = 1'b0;

        // Asynchronous reset at word 9, restart from address 0
        repeat (3) @(negedge clk);
        wr_seen = 0;
        expect_copy();
        pulse_start();
        wait_writes("copy3_w9", 9);
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset("midreset_async");
        exp_q.delete();
        exp_cmd_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) check_reset("midreset_hold");
        wr_seen = 0;
        expect_copy();
        reset_n = 1'b1;
        wait_done("copy3");
        post_checks("copy3", 1'b0);

        // Corrupted trailer: flagged only when the checksum check is built in
        repeat (3) @(negedge clk);
        corrupt = 1'b1;
        wr_seen = 0;
        expect_copy();
        pulse_start();
        wait_done("copy4");
        post_checks("copy4", CSUM);
        corrupt = 1'b0;

        // AUTO_START=0 instance: idle until its start pulse
        check("manual_cs_n_idle", 32'(m_cs_n), 1);
        check("manual_cpu_idle", 32'(m_cpu), 1);
        check("manual_busy_idle", 32'(m_busy), 0);
        check("manual_sclk_idle", 32'(m_sclk), 0);
        check("manual_no_writes", m_writes, 0);
        @(posedge clk) #1 m_start = 1'b1;
        @(posedge clk) #1 m_start = 1'b0;
        @(negedge clk);
        check("manual_busy_started", 32'(m_busy), 1);
        check("manual_cs_n_started", 32'(m_cs_n), 0);
        check("manual_cpu_started", 32'(m_cpu), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
